// File: rtl/sc_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reg_bank_pkg
//  Description : Shared types for the sc_reg_bank register file: the write
//                operation encoding used by the bus interface, the operation
//                unit and the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_reg_bank_pkg;

    // Write operation applied to the addressed word.
    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_INC  = 2'b01,
        MODE_DEC  = 2'b10,
        MODE_SHL  = 2'b11
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/sc_reg_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reg_bank_if
//  Description : Bus bundle of the register bank: one active-low write port,
//                two read ports and the Zero/Carry flags.
//                master : the datapath driving writes and read addresses
//                slave  : the register bank itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface sc_reg_bank_if
    import sc_reg_bank_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDRWIDTH     = 3
);

    logic                     SC_RegBANK_Write_InLow;
    logic [ADDRWIDTH-1:0]     SC_RegBANK_WriteAddr_In;
    mode_t                    SC_RegBANK_Mode_In;
    logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUS_In;
    logic [ADDRWIDTH-1:0]     SC_RegBANK_ReadAddrA_In;
    logic [ADDRWIDTH-1:0]     SC_RegBANK_ReadAddrB_In;
    logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataA_Out;
    logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataB_Out;
    logic                     SC_RegBANK_Zero_Out;
    logic                     SC_RegBANK_Carry_Out;

    modport master (
        output SC_RegBANK_Write_InLow,
        output SC_RegBANK_WriteAddr_In,
        output SC_RegBANK_Mode_In,
        output SC_RegBANK_DataBUS_In,
        output SC_RegBANK_ReadAddrA_In,
        output SC_RegBANK_ReadAddrB_In,
        input  SC_RegBANK_DataA_Out,
        input  SC_RegBANK_DataB_Out,
        input  SC_RegBANK_Zero_Out,
        input  SC_RegBANK_Carry_Out
    );

    modport slave (
        input  SC_RegBANK_Write_InLow,
        input  SC_RegBANK_WriteAddr_In,
        input  SC_RegBANK_Mode_In,
        input  SC_RegBANK_DataBUS_In,
        input  SC_RegBANK_ReadAddrA_In,
        input  SC_RegBANK_ReadAddrB_In,
        output SC_RegBANK_DataA_Out,
        output SC_RegBANK_DataB_Out,
        output SC_RegBANK_Zero_Out,
        output SC_RegBANK_Carry_Out
    );

endinterface
`default_nettype wire

// File: rtl/sc_reg_bank_op.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reg_bank_op
//  Description : Combinational write operation unit. Computes the next value
//                of a word from its stored value, the operation and the load
//                data, plus the carry and zero flags of the result.
//  Ports       : SC_RegOP_Cur_In    current stored word
//                SC_RegOP_Mode_In   LOAD / INC / DEC / SHL
//                SC_RegOP_Data_In   load data (LOAD only)
//                SC_RegOP_Next_Out  next value
//                SC_RegOP_Carry_Out carry / borrow / shifted-out bit
//                SC_RegOP_Zero_Out  next value equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_reg_bank_op
    import sc_reg_bank_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32
) (
    input  wire logic [DATAWIDTH_BUS-1:0] SC_RegOP_Cur_In,
    input  wire mode_t                    SC_RegOP_Mode_In,
    input  wire logic [DATAWIDTH_BUS-1:0] SC_RegOP_Data_In,
    output logic      [DATAWIDTH_BUS-1:0] SC_RegOP_Next_Out,
    output logic                          SC_RegOP_Carry_Out,
    output logic                          SC_RegOP_Zero_Out
);

    localparam logic [DATAWIDTH_BUS:0] c_ONE = {{DATAWIDTH_BUS{1'b0}}, 1'b1};

    logic [DATAWIDTH_BUS:0] w_wide;

    // The extra top bit of the widened result is the carry for INC and the
    // borrow for DEC (it is set only when cur-1 wraps from zero).
    always_comb begin
        w_wide = {1'b0, SC_RegOP_Cur_In};
        case (SC_RegOP_Mode_In)
            MODE_LOAD: w_wide = {1'b0, SC_RegOP_Data_In};
            MODE_INC:  w_wide = {1'b0, SC_RegOP_Cur_In} + c_ONE;
            MODE_DEC:  w_wide = {1'b0, SC_RegOP_Cur_In} - c_ONE;
            MODE_SHL:  w_wide = {SC_RegOP_Cur_In, 1'b0};
            default:   w_wide = {1'b0, SC_RegOP_Cur_In};
        endcase
    end

    assign SC_RegOP_Next_Out  = w_wide[DATAWIDTH_BUS-1:0];
    assign SC_RegOP_Carry_Out = w_wide[DATAWIDTH_BUS];
    assign SC_RegOP_Zero_Out  = (w_wide[DATAWIDTH_BUS-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/sc_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reg_bank
//  Description : CPU register file. NUM_REGS words of DATAWIDTH_BUS bits with
//                one active-low write port applying LOAD/INC/DEC/SHL to the
//                addressed word, registered Zero/Carry flags and two
//                combinational read ports with optional write bypass.
//  Ports       : SC_RegGENERAL_CLOCK_50     clock, rising edge
//                SC_RegGENERAL_RESET_InHigh asynchronous active-high reset
//                bus (slave)                write strobe/address/mode/data,
//                                           read addresses A/B, read data A/B,
//                                           Zero and Carry flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_reg_bank
    import sc_reg_bank_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NUM_REGS      = 8,
    parameter int ADDRWIDTH     = 3,
    parameter bit R0_ZERO       = 1'b1,
    parameter bit BYPASS        = 1'b1
) (
    input wire logic     SC_RegGENERAL_CLOCK_50,
    input wire logic     SC_RegGENERAL_RESET_InHigh,
    sc_reg_bank_if.slave bus
);

    // Array is sized to the full address space so any address indexes it
    // directly; slots without a physical register read as constant zero.
    localparam int c_DEPTH = 2 ** ADDRWIDTH;

    logic [DATAWIDTH_BUS-1:0] w_regWord [c_DEPTH];
    logic [DATAWIDTH_BUS-1:0] w_curWord;
    logic [DATAWIDTH_BUS-1:0] w_nextValue;
    logic                     w_nextCarry;
    logic                     w_nextZero;
    logic                     w_writeAccept;
    logic                     r_zero;
    logic                     r_carry;
    logic [DATAWIDTH_BUS-1:0] w_dataA;
    logic [DATAWIDTH_BUS-1:0] w_dataB;

    // An address maps to a writable, readable register.
    function automatic logic isLiveAddr(input logic [ADDRWIDTH-1:0] addr);
        return (int'(addr) < NUM_REGS) && !(R0_ZERO && (addr == '0));
    endfunction

    // Reset is folded in so that a reset arriving mid-cycle also kills the
    // bypass path and every output reads zero before the next edge.
    assign w_writeAccept = !SC_RegGENERAL_RESET_InHigh
                        && !bus.SC_RegBANK_Write_InLow
                        && isLiveAddr(bus.SC_RegBANK_WriteAddr_In);

    assign w_curWord = w_regWord[bus.SC_RegBANK_WriteAddr_In];

    sc_reg_bank_op #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_op (
        .SC_RegOP_Cur_In    (w_curWord),
        .SC_RegOP_Mode_In   (bus.SC_RegBANK_Mode_In),
        .SC_RegOP_Data_In   (bus.SC_RegBANK_DataBUS_In),
        .SC_RegOP_Next_Out  (w_nextValue),
        .SC_RegOP_Carry_Out (w_nextCarry),
        .SC_RegOP_Zero_Out  (w_nextZero)
    );

    genvar g;
    generate
        for (g = 0; g < c_DEPTH; g++) begin : g_word
            if ((g < NUM_REGS) && !(R0_ZERO && (g == 0))) begin : g_reg
                logic [DATAWIDTH_BUS-1:0] r_word;

                always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
                    if (SC_RegGENERAL_RESET_InHigh) begin
                        r_word <= '0;
                    end else if (w_writeAccept && (bus.SC_RegBANK_WriteAddr_In == ADDRWIDTH'(g))) begin
                        r_word <= w_nextValue;
                    end
                end

                assign w_regWord[g] = r_word;
            end else begin : g_zero
                assign w_regWord[g] = '0;
            end
        end
    endgenerate

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_writeAccept) begin
            r_zero  <= w_nextZero;
            r_carry <= w_nextCarry;
        end
    end

    always_comb begin
        w_dataA = '0;
        if (isLiveAddr(bus.SC_RegBANK_ReadAddrA_In)) begin
            if (BYPASS && w_writeAccept && (bus.SC_RegBANK_ReadAddrA_In == bus.SC_RegBANK_WriteAddr_In)) begin
                w_dataA = w_nextValue;
            end else begin
                w_dataA = w_regWord[bus.SC_RegBANK_ReadAddrA_In];
            end
        end
    end

    always_comb begin
        w_dataB = '0;
        if (isLiveAddr(bus.SC_RegBANK_ReadAddrB_In)) begin
            if (BYPASS && w_writeAccept && (bus.SC_RegBANK_ReadAddrB_In == bus.SC_RegBANK_WriteAddr_In)) begin
                w_dataB = w_nextValue;
            end else begin
                w_dataB = w_regWord[bus.SC_RegBANK_ReadAddrB_In];
            end
        end
    end

    assign bus.SC_RegBANK_DataA_Out  = w_dataA;
    assign bus.SC_RegBANK_DataB_Out  = w_dataB;
    assign bus.SC_RegBANK_Zero_Out   = r_zero;
    assign bus.SC_RegBANK_Carry_Out  = r_carry;

endmodule
`default_nettype wire
